// File: rtl/oled_sequencer.sv
// ============================================================================
// Module      : oled_sequencer
// Description : SSD1306 128x32 OLED sequencer. It drives the panel reset pin,
//               sends the power-on init list, then arbitrates host command
//               bytes against framebuffer refreshes into a byte shifter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module oled_sequencer #(
  parameter int         RESET_CYCLES  = 27000,
  parameter int         STARTUP_DELAY = 2700000,
  parameter int         FB_ADDR_W     = 9,
  parameter logic [7:0] COL_END       = 8'h7F,
  parameter logic [7:0] PAGE_END      = 8'h03
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 res,
  output logic [7:0]           tx_byte,
  output logic                 tx_dc,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 fb_rd_en,
  output logic [FB_ADDR_W-1:0] fb_addr,
  input  logic [7:0]           fb_data,
  input  logic                 frame_req,
  input  logic                 host_cmd_valid,
  input  logic [7:0]           host_cmd_byte,
  output logic                 host_cmd_ready,
  output logic                 init_done,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int CNT_MAX = (RESET_CYCLES > STARTUP_DELAY) ? RESET_CYCLES : STARTUP_DELAY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [FB_ADDR_W-1:0] FB_LAST = {FB_ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    S_RST_LO   = 3'd0,
    S_RST_WAIT = 3'd1,
    S_INIT     = 3'd2,
    S_IDLE     = 3'd3,
    S_HOST     = 3'd4,
    S_WIN      = 3'd5,
    S_FETCH    = 3'd6,
    S_STREAM   = 3'd7
  } state_t;

  function automatic logic [7:0] init_rom(input logic [4:0] idx);
    case (idx)
      5'd0:  init_rom = 8'hAE;
      5'd1:  init_rom = 8'hD5;
      5'd2:  init_rom = 8'h80;
      5'd3:  init_rom = 8'hA8;
      5'd4:  init_rom = 8'h1F;
      5'd5:  init_rom = 8'hD3;
      5'd6:  init_rom = 8'h00;
      5'd7:  init_rom = 8'h40;
      5'd8:  init_rom = 8'h8D;
      5'd9:  init_rom = 8'h14;
      5'd10: init_rom = 8'h20;
      5'd11: init_rom = 8'h00;
      5'd12: init_rom = 8'hA1;
      5'd13: init_rom = 8'hC8;
      5'd14: init_rom = 8'hDA;
      5'd15: init_rom = 8'h02;
      5'd16: init_rom = 8'h81;
      5'd17: init_rom = 8'h8F;
      5'd18: init_rom = 8'hD9;
      5'd19: init_rom = 8'hF1;
      5'd20: init_rom = 8'hDB;
      5'd21: init_rom = 8'h40;
      5'd22: init_rom = 8'hA4;
      5'd23: init_rom = 8'hA6;
      5'd24: init_rom = 8'hAF;
      default: init_rom = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] win_rom(input logic [2:0] idx);
    case (idx)
      3'd0:    win_rom = 8'h21;
      3'd1:    win_rom = 8'h00;
      3'd2:    win_rom = COL_END;
      3'd3:    win_rom = 8'h22;
      3'd4:    win_rom = 8'h00;
      default: win_rom = PAGE_END;
    endcase
  endfunction

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [4:0]           idx_q, idx_d;
  logic                 res_q, res_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic                 tx_dc_q, tx_dc_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 fb_rd_en_q, fb_rd_en_d;
  logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic                 host_cmd_ready_q, host_cmd_ready_d;
  logic                 init_done_q, init_done_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic                 pend_q, pend_d;
  logic                 xfer;

  assign xfer = tx_valid_q && tx_ready;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    idx_d            = idx_q;
    res_d            = res_q;
    tx_byte_d        = tx_byte_q;
    tx_dc_d          = tx_dc_q;
    tx_valid_d       = tx_valid_q;
    fb_rd_en_d       = 1'b0;
    fb_addr_d        = fb_addr_q;
    host_cmd_ready_d = host_cmd_ready_q;
    init_done_d      = init_done_q;
    busy_d           = busy_q;
    frame_done_d     = 1'b0;
    pend_d           = pend_q;

    if (frame_req && state_q != S_IDLE) begin
      pend_d = 1'b1;
    end

    case (state_q)
      S_RST_LO: begin
        res_d = 1'b0;
        if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
          cnt_d   = '0;
          res_d   = 1'b1;
          state_d = S_RST_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RST_WAIT: begin
        if (cnt_q == CNT_W'(STARTUP_DELAY - 1)) begin
          state_d    = S_INIT;
          idx_d      = 5'd0;
          tx_valid_d = 1'b1;
          tx_byte_d  = init_rom(5'd0);
          tx_dc_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_INIT: begin
        if (xfer) begin
          if (idx_q == 5'd24) begin
            tx_valid_d       = 1'b0;
            init_done_d      = 1'b1;
            host_cmd_ready_d = 1'b1;
            busy_d           = 1'b0;
            state_d          = S_IDLE;
          end else begin
            idx_d     = idx_q + 5'd1;
            tx_byte_d = init_rom(idx_q + 5'd1);
          end
        end
      end
      S_IDLE: begin
        // A frame request arriving alongside an accepted host byte is kept.
        if (host_cmd_valid) begin
          tx_byte_d        = host_cmd_byte;
          tx_dc_d          = 1'b0;
          tx_valid_d       = 1'b1;
          host_cmd_ready_d = 1'b0;
          busy_d           = 1'b1;
          state_d          = S_HOST;
          if (frame_req) begin
            pend_d = 1'b1;
          end
        end else if (pend_q || frame_req) begin
          pend_d           = 1'b0;
          idx_d            = 5'd0;
          tx_byte_d        = win_rom(3'd0);
          tx_dc_d          = 1'b0;
          tx_valid_d       = 1'b1;
          host_cmd_ready_d = 1'b0;
          busy_d           = 1'b1;
          state_d          = S_WIN;
        end
      end
      S_HOST: begin
        if (xfer) begin
          tx_valid_d       = 1'b0;
          host_cmd_ready_d = 1'b1;
          busy_d           = 1'b0;
          state_d          = S_IDLE;
        end
      end
      S_WIN: begin
        if (xfer) begin
          if (idx_q == 5'd5) begin
            tx_valid_d = 1'b0;
            fb_addr_d  = '0;
            fb_rd_en_d = 1'b1;
            state_d    = S_FETCH;
          end else begin
            idx_d     = idx_q + 5'd1;
            tx_byte_d = win_rom(idx_q[2:0] + 3'd1);
          end
        end
      end
      S_FETCH: begin
        // First cycle issues the read; second cycle has fb_data valid.
        if (!fb_rd_en_q) begin
          tx_byte_d  = fb_data;
          tx_dc_d    = 1'b1;
          tx_valid_d = 1'b1;
          state_d    = S_STREAM;
        end
      end
      S_STREAM: begin
        if (xfer) begin
          tx_valid_d = 1'b0;
          if (fb_addr_q == FB_LAST) begin
            frame_done_d     = 1'b1;
            host_cmd_ready_d = 1'b1;
            busy_d           = 1'b0;
            state_d          = S_IDLE;
          end else begin
            fb_addr_d  = fb_addr_q + FB_ADDR_W'(1);
            fb_rd_en_d = 1'b1;
            state_d    = S_FETCH;
          end
        end
      end
      default: state_d = S_RST_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= S_RST_LO;
      cnt_q            <= '0;
      idx_q            <= 5'd0;
      res_q            <= 1'b0;
      tx_byte_q        <= 8'h00;
      tx_dc_q          <= 1'b0;
      tx_valid_q       <= 1'b0;
      fb_rd_en_q       <= 1'b0;
      fb_addr_q        <= '0;
      host_cmd_ready_q <= 1'b0;
      init_done_q      <= 1'b0;
      busy_q           <= 1'b1;
      frame_done_q     <= 1'b0;
      pend_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      idx_q            <= idx_d;
      res_q            <= res_d;
      tx_byte_q        <= tx_byte_d;
      tx_dc_q          <= tx_dc_d;
      tx_valid_q       <= tx_valid_d;
      fb_rd_en_q       <= fb_rd_en_d;
      fb_addr_q        <= fb_addr_d;
      host_cmd_ready_q <= host_cmd_ready_d;
      init_done_q      <= init_done_d;
      busy_q           <= busy_d;
      frame_done_q     <= frame_done_d;
      pend_q           <= pend_d;
    end
  end

  assign res            = res_q;
  assign tx_byte        = tx_byte_q;
  assign tx_dc          = tx_dc_q;
  assign tx_valid       = tx_valid_q;
  assign fb_rd_en       = fb_rd_en_q;
  assign fb_addr        = fb_addr_q;
  assign host_cmd_ready = host_cmd_ready_q;
  assign init_done      = init_done_q;
  assign busy           = busy_q;
  assign frame_done     = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_oled_sequencer.sv
// ============================================================================
// Module      : tb_oled_sequencer
// Description : Self-checking bench for oled_sequencer with a byte-stream
//               reference model and randomized shifter back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_oled_sequencer;

  localparam int RC = 4;
  localparam int SD = 10;
  localparam int AW = 3;
  localparam int NB = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          res;
  logic [7:0]    tx_byte;
  logic          tx_dc;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          fb_rd_en;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_data = 8'h00;
  logic          frame_req = 1'b0;
  logic          host_cmd_valid = 1'b0;
  logic [7:0]    host_cmd_byte = 8'h00;
  logic          host_cmd_ready;
  logic          init_done;
  logic          busy;
  logic          frame_done;

  oled_sequencer #(
    .RESET_CYCLES (RC),
    .STARTUP_DELAY(SD),
    .FB_ADDR_W    (AW),
    .COL_END      (8'h7F),
    .PAGE_END     (8'h03)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .res           (res),
    .tx_byte       (tx_byte),
    .tx_dc         (tx_dc),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .fb_rd_en      (fb_rd_en),
    .fb_addr       (fb_addr),
    .fb_data       (fb_data),
    .frame_req     (frame_req),
    .host_cmd_valid(host_cmd_valid),
    .host_cmd_byte (host_cmd_byte),
    .host_cmd_ready(host_cmd_ready),
    .init_done     (init_done),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] init_list [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h1F, 8'hD3, 8'h00,
                                 8'h40, 8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8,
                                 8'hDA, 8'h02, 8'h81, 8'h8F, 8'hD9, 8'hF1, 8'hDB,
                                 8'h40, 8'hA4, 8'hA6, 8'hAF};
  logic [7:0] win_list [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h03};
  logic [7:0] fb_mem [NB];
  logic [8:0] exp_q [$];
  logic [8:0] got_q [$];

  always @(posedge clk) begin
    if (fb_rd_en) fb_data <= fb_mem[fb_addr];
  end

  // 0: always ready, 1: random, 2: stalled
  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ($urandom % 3) != 0;
      default: tx_ready = 1'b0;
    endcase
  end

  int         fdone_cnt = 0;
  logic       prev_stall = 1'b0;
  logic       prev_rd = 1'b0;
  logic [8:0] prev_word = 9'h0;
  int         rd_exp = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (prev_stall) begin
        chk("hold_valid", {31'd0, tx_valid}, 32'd1);
        chk("hold_word", {23'd0, tx_dc, tx_byte}, {23'd0, prev_word});
      end
      if (tx_valid && tx_ready) got_q.push_back({tx_dc, tx_byte});
      if (frame_done) fdone_cnt++;
      if (host_cmd_ready) chk("ready_only_idle", {31'd0, busy}, 32'd0);
      if (fb_rd_en) begin
        chk("rd_pulse", {31'd0, prev_rd}, 32'd0);
        chk("rd_addr", {29'd0, fb_addr}, rd_exp);
        rd_exp = (rd_exp + 1) % NB;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_word  = {tx_dc, tx_byte};
      prev_rd    = fb_rd_en;
    end else begin
      prev_stall = 1'b0;
      prev_rd    = 1'b0;
      rd_exp     = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, win_list[i]});
    for (int n = 0; n < NB; n++) exp_q.push_back({1'b1, fb_mem[n]});
  endtask

  task automatic fill_fb_random();
    for (int n = 0; n < NB; n++) fb_mem[n] = 8'($urandom);
  endtask

  task automatic compare_stream(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_byte"}, {23'd0, got_q[i]}, {23'd0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_idle(input int bound);
    int run = 0;
    for (int i = 0; i < bound && run < 3; i++) begin
      @(negedge clk);
      run = busy ? 0 : run + 1;
    end
    chk("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic pulse_frame();
    tick();
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
  endtask

  task automatic host_send(input logic [7:0] b);
    int i;
    tick();
    host_cmd_valid = 1'b1;
    host_cmd_byte  = b;
    for (i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (host_cmd_ready) break;
    end
    if (i == 2000) chk("host_accept", {31'd0, host_cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    host_cmd_valid = 1'b0;
  endtask

  // Holds reset, releases it and checks the reset/startup timing and init list.
  task automatic reset_init(input bit first_run);
    int lo;
    int d;
    int i;
    reset = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_state",
        {13'd0, res, tx_valid, tx_byte, tx_dc, fb_rd_en, fb_addr, host_cmd_ready, init_done, busy, frame_done},
        {13'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0});
    tick();
    reset = 1'b1;
    push_init();
    lo = 0;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (res) break;
      lo++;
    end
    chk("res_low_cycles", lo, RC);
    if (!first_run) begin
      #1 frame_req = 1'b1;
      @(posedge clk);
      #1 frame_req = 1'b0;
      push_frame();
    end
    d = 0;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      d++;
      if (tx_valid) break;
    end
    chk("startup_delay", d, SD);
    chk("first_byte", {23'd0, tx_dc, tx_byte}, {23'd0, 1'b0, 8'hAE});
    if (first_run) begin
      for (i = 0; i < 200; i++) begin
        @(negedge clk);
        if (tx_valid && tx_ready && tx_byte == 8'h40) break;
      end
      ready_mode = 2;
      for (int k = 0; k < 7; k++) begin
        @(negedge clk);
        chk("stall_8d", {22'd0, tx_valid, tx_dc, tx_byte}, {22'd0, 1'b1, 1'b0, 8'h8D});
      end
      ready_mode = 0;
    end
    for (i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx_valid && tx_ready && tx_byte == 8'hAF) break;
    end
    chk("init_done_before", {31'd0, init_done}, 32'd0);
    @(negedge clk);
    chk("init_done_after", {31'd0, init_done}, 32'd1);
    wait_idle(2000);
    compare_stream(first_run ? "init1" : "init2");
  endtask

  task automatic push_init();
    for (int i = 0; i < 25; i++) exp_q.push_back({1'b0, init_list[i]});
  endtask

  initial begin
    int f0;
    int i;
    logic [7:0] b;
    for (int n = 0; n < NB; n++) fb_mem[n] = 8'hA0 + 8'(n);

    reset_init(1'b1);

    // Single frame with known contents under random back-pressure.
    ready_mode = 1;
    f0 = fdone_cnt;
    push_frame();
    pulse_frame();
    wait_idle(1000);
    compare_stream("frame1");
    chk("frame_done_once", fdone_cnt - f0, 1);

    // Host byte and frame request in the same IDLE cycle.
    fill_fb_random();
    tick();
    chk("idle_ready", {31'd0, host_cmd_ready}, 32'd1);
    host_cmd_valid = 1'b1;
    host_cmd_byte  = 8'h81;
    frame_req      = 1'b1;
    tick();
    host_cmd_valid = 1'b0;
    frame_req      = 1'b0;
    exp_q.push_back({1'b0, 8'h81});
    push_frame();
    wait_idle(1000);
    compare_stream("host_vs_frame");

    // Random host bytes, one of them offered while a frame is streaming.
    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom);
      exp_q.push_back({1'b0, b});
      host_send(b);
      wait_idle(500);
    end
    fill_fb_random();
    push_frame();
    pulse_frame();
    b = 8'($urandom);
    exp_q.push_back({1'b0, b});
    host_send(b);
    wait_idle(1000);
    compare_stream("host_wait");

    // Three requests during streaming collapse into one extra frame.
    fill_fb_random();
    f0 = fdone_cnt;
    push_frame();
    push_frame();
    pulse_frame();
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (fb_rd_en) break;
    end
    for (int k = 0; k < 3; k++) begin
      pulse_frame();
      repeat (3) tick();
    end
    wait_idle(2000);
    repeat (20) @(negedge clk);
    chk("no_extra_busy", {31'd0, busy}, 32'd0);
    compare_stream("collapse");
    chk("collapse_done_cnt", fdone_cnt - f0, 2);

    // Reset while the byte at address 5 is stalled on the shifter.
    fill_fb_random();
    for (int k = 0; k < 6; k++) exp_q.push_back({1'b0, win_list[k]});
    for (int n = 0; n < 5; n++) exp_q.push_back({1'b1, fb_mem[n]});
    pulse_frame();
    for (i = 0; i < 500; i++) begin
      @(negedge clk);
      if (fb_rd_en && fb_addr == 3'd5) break;
    end
    ready_mode = 2;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_valid) break;
    end
    chk("abort_byte", {23'd0, tx_dc, tx_byte}, {23'd0, 1'b1, fb_mem[5]});
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_state", {28'd0, tx_valid, res, init_done, busy}, {28'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    compare_stream("abort");

    ready_mode = 1;
    reset_init(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
